cmd_cfg: RTL and testbench

CMD_CFG -- requirements
Module: cmd_cfg

---
 rtl/quad_cmd_pkg.sv | 29 ++
 rtl/cal_timer.sv | 38 +++
 rtl/cmd_cfg.sv | 155 +++++++++++++++
 tb/tb_cmd_cfg.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_cmd_pkg.sv
// Shared opcodes, acknowledge bytes, FSM states and spin-up timer width for cmd_cfg.
// Defining CMD_CFG_FAST_SIM_EN shortens the spin-up timer from 2^26 to 2^9 cycles.
package quad_cmd_pkg;

  localparam logic [7:0] CMD_SET_PTCH  = 8'h02;
  localparam logic [7:0] CMD_SET_ROLL  = 8'h03;
  localparam logic [7:0] CMD_SET_YAW   = 8'h04;
  localparam logic [7:0] CMD_SET_THRST = 8'h05;
  localparam logic [7:0] CMD_CALIBRATE = 8'h06;
  localparam logic [7:0] CMD_EMER_LAND = 8'h07;
  localparam logic [7:0] CMD_MTRS_OFF  = 8'h08;

  localparam logic [7:0] POS_ACK_DEF = 8'hA5;
  localparam logic [7:0] NEG_ACK_DEF = 8'hEE;

`ifdef CMD_CFG_FAST_SIM_EN
  localparam int unsigned SPINUP_W = 9;
`else
  localparam int unsigned SPINUP_W = 26;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SPINUP  = 2'd1,
    CAL     = 2'd2,
    WAIT_TX = 2'd3
  } state_t;

endpackage

// File: rtl/cal_timer.sv
// Saturating spin-up timer; done stays high once the count reaches all ones.
// Width defaults to SPINUP_W, which follows CMD_CFG_FAST_SIM_EN.
module cal_timer
  import quad_cmd_pkg::*;
#(
  parameter int unsigned W = SPINUP_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign done = &cnt_q;

  // Holding at terminal count keeps done asserted instead of wrapping to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !done) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cmd_cfg.sv
// Host command decoder: applies setpoint/motor commands and runs the spin-up + calibration sequence.
// Spin-up length follows CMD_CFG_FAST_SIM_EN through quad_cmd_pkg::SPINUP_W.
module cmd_cfg
  import quad_cmd_pkg::*;
#(
  parameter logic [7:0]  POS_ACK = POS_ACK_DEF,
  parameter logic [7:0]  NEG_ACK = NEG_ACK_DEF,
  parameter int unsigned TMR_W   = SPINUP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_rdy,
  input  logic [7:0]         cmd,
  input  logic [15:0]        data,
  output logic               clr_cmd_rdy,
  output logic [7:0]         resp,
  output logic               send_resp,
  input  logic               resp_sent,
  output logic signed [15:0] d_ptch,
  output logic signed [15:0] d_roll,
  output logic signed [15:0] d_yaw,
  output logic [8:0]         thrst,
  output logic               inertial_cal,
  output logic               strt_cal,
  input  logic               cal_done,
  output logic               motors_off
);

  state_t             state_q, state_d;
  logic signed [15:0] d_ptch_q, d_ptch_d;
  logic signed [15:0] d_roll_q, d_roll_d;
  logic signed [15:0] d_yaw_q, d_yaw_d;
  logic [8:0]         thrst_q, thrst_d;
  logic               motors_off_q, motors_off_d;
  logic               inertial_cal_q, inertial_cal_d;
  logic [7:0]         resp_q, resp_d;
  logic               send_resp_q, send_resp_d;
  logic               tmr_clr, tmr_en, tmr_done;

  cal_timer #(.W(TMR_W)) u_cal_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .done (tmr_done)
  );

  always_comb begin
    state_d        = state_q;
    d_ptch_d       = d_ptch_q;
    d_roll_d       = d_roll_q;
    d_yaw_d        = d_yaw_q;
    thrst_d        = thrst_q;
    motors_off_d   = motors_off_q;
    inertial_cal_d = inertial_cal_q;
    resp_d         = resp_q;
    send_resp_d    = 1'b0;
    clr_cmd_rdy    = 1'b0;
    strt_cal       = 1'b0;
    tmr_clr        = 1'b0;
    tmr_en         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_rdy) begin
          clr_cmd_rdy = 1'b1;
          resp_d      = POS_ACK;
          send_resp_d = 1'b1;
          state_d     = WAIT_TX;
          case (cmd)
            CMD_SET_PTCH:  d_ptch_d = data;
            CMD_SET_ROLL:  d_roll_d = data;
            CMD_SET_YAW:   d_yaw_d  = data;
            CMD_SET_THRST: thrst_d  = data[8:0];
            CMD_EMER_LAND: begin
              d_ptch_d = '0;
              d_roll_d = '0;
              d_yaw_d  = '0;
              thrst_d  = '0;
            end
            CMD_MTRS_OFF: begin
              motors_off_d = 1'b1;
              thrst_d      = '0;
            end
            // Calibration acknowledges only after cal_done, so no response here.
            CMD_CALIBRATE: begin
              resp_d         = resp_q;
              send_resp_d    = 1'b0;
              motors_off_d   = 1'b0;
              inertial_cal_d = 1'b1;
              tmr_clr        = 1'b1;
              state_d        = SPINUP;
            end
            default: resp_d = NEG_ACK;
          endcase
        end
      end
      SPINUP: begin
        tmr_en = 1'b1;
        if (tmr_done) begin
          strt_cal = 1'b1;
          state_d  = CAL;
        end
      end
      CAL: begin
        if (cal_done) begin
          inertial_cal_d = 1'b0;
          resp_d         = POS_ACK;
          send_resp_d    = 1'b1;
          state_d        = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (resp_sent) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      d_ptch_q       <= '0;
      d_roll_q       <= '0;
      d_yaw_q        <= '0;
      thrst_q        <= '0;
      motors_off_q   <= 1'b1;
      inertial_cal_q <= 1'b0;
      resp_q         <= 8'h00;
      send_resp_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      d_ptch_q       <= d_ptch_d;
      d_roll_q       <= d_roll_d;
      d_yaw_q        <= d_yaw_d;
      thrst_q        <= thrst_d;
      motors_off_q   <= motors_off_d;
      inertial_cal_q <= inertial_cal_d;
      resp_q         <= resp_d;
      send_resp_q    <= send_resp_d;
    end
  end

  assign d_ptch       = d_ptch_q;
  assign d_roll       = d_roll_q;
  assign d_yaw        = d_yaw_q;
  assign thrst        = thrst_q;
  assign motors_off   = motors_off_q;
  assign inertial_cal = inertial_cal_q;
  assign resp         = resp_q;
  assign send_resp    = send_resp_q;

endmodule

// File: tb/tb_cmd_cfg.sv
// Scoreboard bench for cmd_cfg: stimulus pushes expected responses, a monitor checks each send_resp.
// The timer width is overridden to 9 bits so spin-up lasts 512 cycles.
module tb_cmd_cfg;

  logic        clk;
  logic        rst;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;
  logic [15:0] d_ptch;
  logic [15:0] d_roll;
  logic [15:0] d_yaw;
  logic [8:0]  thrst;
  logic        inertial_cal;
  logic        strt_cal;
  logic        cal_done;
  logic        motors_off;

  typedef struct {
    logic [15:0] ptch;
    logic [15:0] roll;
    logic [15:0] yaw;
    logic [8:0]  thrst;
    logic        motors_off;
    logic        inertial_cal;
    logic [7:0]  resp;
    logic        after_clr;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;
  logic clr_prev = 1'b0;

  cmd_cfg #(
    .POS_ACK (8'hA5),
    .NEG_ACK (8'hEE),
    .TMR_W   (9)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_rdy      (cmd_rdy),
    .cmd          (cmd),
    .data         (data),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .resp         (resp),
    .send_resp    (send_resp),
    .resp_sent    (resp_sent),
    .d_ptch       (d_ptch),
    .d_roll       (d_roll),
    .d_yaw        (d_yaw),
    .thrst        (thrst),
    .inertial_cal (inertial_cal),
    .strt_cal     (strt_cal),
    .cal_done     (cal_done),
    .motors_off   (motors_off)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushExpected(input logic [15:0] p, input logic [15:0] r, input logic [15:0] y,
                              input logic [8:0] t, input logic mo, input logic ic,
                              input logic [7:0] rs, input logic ac);
    exp_t e;
    e.ptch = p; e.roll = r; e.yaw = y; e.thrst = t;
    e.motors_off = mo; e.inertial_cal = ic; e.resp = rs; e.after_clr = ac;
    sbq.push_back(e);
  endtask

  // Waits for the response pulse, then completes the host-side transmit handshake.
  task automatic finishResponse();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (send_resp) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("send_resp_seen", 32'(got), 32'd1);
    @(posedge clk); #1 resp_sent = 1'b1;
    @(posedge clk); #1 resp_sent = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] c, input logic [15:0] d);
    int lat;
    @(posedge clk); #1;
    cmd = c; data = d; cmd_rdy = 1'b1;
    lat = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (clr_cmd_rdy) begin
        lat = i;
        break;
      end
    end
    checkOutput($sformatf("clr_latency_cmd%0h", c), 32'(lat), 32'd0);
    @(posedge clk); #1 cmd_rdy = 1'b0;
    finishResponse();
  endtask

  // Monitor: every send_resp must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && send_resp) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_send_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          checkOutput("sb_resp", 32'(resp), 32'(e.resp));
          checkOutput("sb_ptch", 32'(d_ptch), 32'(e.ptch));
          checkOutput("sb_roll", 32'(d_roll), 32'(e.roll));
          checkOutput("sb_yaw", 32'(d_yaw), 32'(e.yaw));
          checkOutput("sb_thrst", 32'(thrst), 32'(e.thrst));
          checkOutput("sb_motors_off", 32'(motors_off), 32'(e.motors_off));
          checkOutput("sb_inertial_cal", 32'(inertial_cal), 32'(e.inertial_cal));
          checkOutput("sb_send_after_clr", 32'(clr_prev), 32'(e.after_clr));
        end
      end
      clr_prev = clr_cmd_rdy;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int strt_at, n_strt, bad_clr, n_send;
    logic got;

    rst = 1'b1; cmd_rdy = 1'b0; cmd = 8'h00; data = 16'h0000;
    resp_sent = 1'b0; cal_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_motors_off", 32'(motors_off), 32'd1);
    checkOutput("rst_thrst", 32'(thrst), 32'd0);
    checkOutput("rst_ptch", 32'(d_ptch), 32'd0);
    checkOutput("rst_roll", 32'(d_roll), 32'd0);
    checkOutput("rst_yaw", 32'(d_yaw), 32'd0);
    checkOutput("rst_resp", 32'(resp), 32'd0);
    checkOutput("rst_inertial_cal", 32'(inertial_cal), 32'd0);
    checkOutput("rst_send_resp", 32'(send_resp), 32'd0);

    // Thrust loads only data[8:0]; motors-off zeroes thrust.
    pushExpected(16'h0000, 16'h0000, 16'h0000, 9'h0FF, 1'b1, 1'b0, 8'hA5, 1'b1);
    applyStimulus(8'h05, 16'h00FF);
    pushExpected(16'h0000, 16'h0000, 16'h0000, 9'h001, 1'b1, 1'b0, 8'hA5, 1'b1);
    applyStimulus(8'h05, 16'hFE01);
    pushExpected(16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b1, 1'b0, 8'hA5, 1'b1);
    applyStimulus(8'h08, 16'h1234);

    // 16'hFF38 is -200 as a signed pitch setpoint.
    pushExpected(16'hFF38, 16'h0000, 16'h0000, 9'h000, 1'b1, 1'b0, 8'hA5, 1'b1);
    applyStimulus(8'h02, 16'hFF38);
    pushExpected(16'hFF38, 16'h7FFF, 16'h0000, 9'h000, 1'b1, 1'b0, 8'hA5, 1'b1);
    applyStimulus(8'h03, 16'h7FFF);
    pushExpected(16'hFF38, 16'h7FFF, 16'h8000, 9'h000, 1'b1, 1'b0, 8'hA5, 1'b1);
    applyStimulus(8'h04, 16'h8000);
    pushExpected(16'hFF38, 16'h7FFF, 16'h8000, 9'h100, 1'b1, 1'b0, 8'hA5, 1'b1);
    applyStimulus(8'h05, 16'h0100);

    // Unknown opcodes leave every register alone.
    pushExpected(16'hFF38, 16'h7FFF, 16'h8000, 9'h100, 1'b1, 1'b0, 8'hEE, 1'b1);
    applyStimulus(8'h3C, 16'hFFFF);
    repeat (3) @(negedge clk);
    checkOutput("resp_hold", 32'(resp), 32'h0EE);
    pushExpected(16'hFF38, 16'h7FFF, 16'h8000, 9'h100, 1'b1, 1'b0, 8'hEE, 1'b1);
    applyStimulus(8'h09, 16'h0000);
    pushExpected(16'hFF38, 16'h7FFF, 16'h8000, 9'h100, 1'b1, 1'b0, 8'hEE, 1'b1);
    applyStimulus(8'h01, 16'h0000);

    pushExpected(16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b1, 1'b0, 8'hA5, 1'b1);
    applyStimulus(8'h07, 16'hABCD);

    // Calibration, with a yaw packet left pending during spin-up.
    pushExpected(16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b0, 1'b0, 8'hA5, 1'b0);
    pushExpected(16'h0000, 16'h0000, 16'h1234, 9'h000, 1'b0, 1'b0, 8'hA5, 1'b1);
    @(posedge clk); #1;
    cmd = 8'h06; data = 16'h0000; cmd_rdy = 1'b1;
    @(negedge clk);
    checkOutput("cal_clr_cmd_rdy", 32'(clr_cmd_rdy), 32'd1);
    @(posedge clk); #1 cmd_rdy = 1'b0;
    strt_at = 0; n_strt = 0; bad_clr = 0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checkOutput("cal_inertial_cal_set", 32'(inertial_cal), 32'd1);
        checkOutput("cal_motors_on", 32'(motors_off), 32'd0);
      end
      if (strt_cal) begin
        n_strt++;
        if (strt_at == 0) strt_at = c;
      end
      if (clr_cmd_rdy) bad_clr++;
      if (c == 5)   begin cmd = 8'h04; data = 16'h1234; cmd_rdy = 1'b1; end
      if (c == 100) cal_done = 1'b1;
      if (c == 101) cal_done = 1'b0;
      if (c == 150) resp_sent = 1'b1;
      if (c == 151) resp_sent = 1'b0;
    end
    checkOutput("strt_cal_cycle", 32'(strt_at), 32'd512);
    checkOutput("strt_cal_pulses", 32'(n_strt), 32'd1);
    checkOutput("pending_not_consumed", 32'(bad_clr), 32'd0);
    checkOutput("cal_still_running", 32'(inertial_cal), 32'd1);

    cal_done = 1'b1;
    @(negedge clk);
    cal_done = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (send_resp) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("cal_send_resp_seen", 32'(got), 32'd1);
    bad_clr = 0;
    repeat (3) begin
      @(negedge clk);
      if (clr_cmd_rdy) bad_clr++;
    end
    checkOutput("pending_held_in_wait_tx", 32'(bad_clr), 32'd0);
    @(posedge clk); #1 resp_sent = 1'b1;
    @(posedge clk); #1 resp_sent = 1'b0;
    @(negedge clk);
    checkOutput("pending_consumed_in_idle", 32'(clr_cmd_rdy), 32'd1);
    @(posedge clk); #1 cmd_rdy = 1'b0;
    finishResponse();

    // Reset in the middle of spin-up aborts calibration silently.
    @(posedge clk); #1;
    cmd = 8'h06; cmd_rdy = 1'b1;
    @(negedge clk);
    checkOutput("abort_clr_cmd_rdy", 32'(clr_cmd_rdy), 32'd1);
    @(posedge clk); #1 cmd_rdy = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("abort_motors_on_before_rst", 32'(motors_off), 32'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_motors_off", 32'(motors_off), 32'd1);
    checkOutput("abort_inertial_cal", 32'(inertial_cal), 32'd0);
    checkOutput("abort_yaw_cleared", 32'(d_yaw), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    n_strt = 0; n_send = 0;
    repeat (600) begin
      @(negedge clk);
      if (strt_cal) n_strt++;
      if (send_resp) n_send++;
    end
    checkOutput("abort_no_strt_cal", 32'(n_strt), 32'd0);
    checkOutput("abort_no_send_resp", 32'(n_send), 32'd0);
    checkOutput("abort_motors_off_after", 32'(motors_off), 32'd1);

    checkOutput("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
